// File: rtl/sqrt_result_collector.sv
// Result collector for the formula distributor: per-channel result slots plus an
// in-order tag FIFO return worker results to the consumer in issue order.
module sqrt_result_collector #(
  parameter int N = 8,
  parameter int W = 32,
  localparam int CW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_vld_i,
  input  logic [CW-1:0]   issue_ch_i,
  output logic            issue_rdy_o,
  input  logic [N-1:0]    ch_res_vld_i,
  input  logic [N*W-1:0]  ch_res_i,
  output logic [N-1:0]    ch_free_o,
  output logic            res_vld_o,
  output logic [W-1:0]    res_o,
  output logic [CW-1:0]   res_ch_o,
  input  logic            res_rdy_i,
  output logic            err_issue_o,
  output logic            err_unexp_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } st_e;

  localparam logic [CW:0]   FULL_CNT = (CW+1)'(N);
  localparam logic [CW:0]   ZERO_CNT = (CW+1)'(0);
  localparam logic [CW:0]   ONE_CNT  = (CW+1)'(1);
  localparam logic [CW-1:0] LAST_PTR = CW'(N - 1);

  st_e            st_q [N];
  st_e            st_d [N];
  logic [W-1:0]   slot_q [N];
  logic [CW-1:0]  fifo_q [N];
  logic [CW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CW:0]    cnt_q, cnt_d;
  logic [N-1:0]   free_q, free_d;
  logic           err_issue_q, err_unexp_q;
  logic [N-1:0]   cap_s, unexp_s;
  logic [CW-1:0]  head_ch_s;
  logic           full_s, empty_s, push_s, pop_s;

  function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
    ptr_inc = (p == LAST_PTR) ? CW'(0) : p + CW'(1);
  endfunction

  assign full_s      = (cnt_q == FULL_CNT);
  assign empty_s     = (cnt_q == ZERO_CNT);
  assign head_ch_s   = fifo_q[head_q];
  assign issue_rdy_o = free_q[issue_ch_i] && !full_s;
  assign push_s      = issue_vld_i && issue_rdy_o;
  assign res_vld_o   = !empty_s && (st_q[head_ch_s] == ST_DONE);
  assign pop_s       = res_vld_o && res_rdy_i;
  assign res_o       = res_vld_o ? slot_q[head_ch_s] : {W{1'b0}};
  assign res_ch_o    = res_vld_o ? head_ch_s : {CW{1'b0}};
  assign ch_free_o   = free_q;
  assign err_issue_o = err_issue_q;
  assign err_unexp_o = err_unexp_q;

  // Per-channel next state; a pop on the same channel as an issue cannot
  // coincide because issue needs IDLE while pop needs DONE.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cap_s[i]   = ch_res_vld_i[i] && (st_q[i] == ST_BUSY);
      unexp_s[i] = ch_res_vld_i[i] && (st_q[i] != ST_BUSY);
      st_d[i]    = st_q[i];
      case (st_q[i])
        ST_IDLE: begin
          if (push_s && (issue_ch_i == CW'(i))) st_d[i] = ST_BUSY;
          else                                  st_d[i] = ST_IDLE;
        end
        ST_BUSY: begin
          if (cap_s[i]) st_d[i] = ST_DONE;
          else          st_d[i] = ST_BUSY;
        end
        ST_DONE: begin
          if (pop_s && (head_ch_s == CW'(i))) st_d[i] = ST_IDLE;
          else                                st_d[i] = ST_DONE;
        end
        default: st_d[i] = ST_IDLE;
      endcase
      free_d[i] = (st_d[i] == ST_IDLE);
    end
  end

  // Tag FIFO pointer and occupancy update.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_s) head_d = ptr_inc(head_q);
    else       head_d = head_q;
    if (push_s) tail_d = ptr_inc(tail_q);
    else        tail_d = tail_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + ONE_CNT;
      2'b01:   cnt_d = cnt_q - ONE_CNT;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) st_q[i] <= ST_IDLE;
      free_q      <= {N{1'b1}};
      head_q      <= {CW{1'b0}};
      tail_q      <= {CW{1'b0}};
      cnt_q       <= ZERO_CNT;
      err_issue_q <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) st_q[i] <= st_d[i];
      free_q      <= free_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      err_issue_q <= issue_vld_i && !issue_rdy_o;
      err_unexp_q <= |unexp_s;
    end
  end

  // Data storage: tag FIFO entries and result slots need no reset.
  always_ff @(posedge clk) begin
    if (push_s) fifo_q[tail_q] <= issue_ch_i;
    for (int i = 0; i < N; i++) begin
      if (cap_s[i]) slot_q[i] <= ch_res_i[i*W +: W];
    end
  end

endmodule

// File: tb/tb_sqrt_result_collector.sv
// Self-checking bench for sqrt_result_collector: directed scenarios plus random
// traffic checked against a job-queue reference model.
module tb_sqrt_result_collector;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           issue_vld;
  logic [CW-1:0]  issue_ch;
  logic           issue_rdy;
  logic [N-1:0]   ch_res_vld;
  logic [N*W-1:0] ch_res;
  logic [N-1:0]   ch_free;
  logic           res_vld;
  logic [W-1:0]   res;
  logic [CW-1:0]  res_ch;
  logic           res_rdy;
  logic           err_issue;
  logic           err_unexp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         ch;
    bit         have;
    logic [W-1:0] val;
  } job_t;

  job_t jq[$];
  bit   e_err_iss;
  bit   e_err_unx;

  always #5 clk = ~clk;

  sqrt_result_collector #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .issue_vld_i(issue_vld), .issue_ch_i(issue_ch), .issue_rdy_o(issue_rdy),
    .ch_res_vld_i(ch_res_vld), .ch_res_i(ch_res), .ch_free_o(ch_free),
    .res_vld_o(res_vld), .res_o(res), .res_ch_o(res_ch), .res_rdy_i(res_rdy),
    .err_issue_o(err_issue), .err_unexp_o(err_unexp)
  );

  function automatic int find_job(input int ch);
    foreach (jq[k]) if (jq[k].ch == ch) return k;
    return -1;
  endfunction

  // One clock of stimulus: compare every output to the model, then advance the model.
  task automatic run_cycle(input bit r, input bit iv, input logic [CW-1:0] ic,
                           input logic [N-1:0] rv, input logic [N*W-1:0] rd, input bit rr);
    bit           ev, erdy, acc;
    logic [W-1:0] eres;
    logic [CW-1:0] ech;
    logic [N-1:0] ef;
    int           k;
    rst = r; issue_vld = iv; issue_ch = ic; ch_res_vld = rv; ch_res = rd; res_rdy = rr;
    @(negedge clk);
    ev   = (jq.size() > 0) && jq[0].have;
    eres = ev ? jq[0].val : '0;
    ech  = ev ? CW'(jq[0].ch) : '0;
    erdy = (find_job(int'(ic)) < 0) && (jq.size() < N);
    for (int c = 0; c < N; c++) ef[c] = (find_job(c) < 0);
    checks++; if (res_vld !== ev) begin errors++; $display("FAIL res_vld got %0b want %0b at %0t", res_vld, ev, $time); end
    checks++; if (res !== eres) begin errors++; $display("FAIL res got %0d want %0d at %0t", res, eres, $time); end
    checks++; if (res_ch !== ech) begin errors++; $display("FAIL res_ch got %0d want %0d at %0t", res_ch, ech, $time); end
    checks++; if (issue_rdy !== erdy) begin errors++; $display("FAIL issue_rdy got %0b want %0b at %0t", issue_rdy, erdy, $time); end
    checks++; if (ch_free !== ef) begin errors++; $display("FAIL ch_free got %b want %b at %0t", ch_free, ef, $time); end
    checks++; if (err_issue !== e_err_iss) begin errors++; $display("FAIL err_issue got %0b want %0b at %0t", err_issue, e_err_iss, $time); end
    checks++; if (err_unexp !== e_err_unx) begin errors++; $display("FAIL err_unexp got %0b want %0b at %0t", err_unexp, e_err_unx, $time); end
    @(posedge clk);
    if (r) begin
      jq.delete();
      e_err_iss = 1'b0;
      e_err_unx = 1'b0;
    end else begin
      acc = iv && erdy;
      e_err_iss = iv && !erdy;
      if (ev && rr) void'(jq.pop_front());
      e_err_unx = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (rv[c]) begin
          k = find_job(c);
          if (k >= 0 && !jq[k].have) begin
            jq[k].have = 1'b1;
            jq[k].val  = rd[c*W +: W];
          end else begin
            e_err_unx = 1'b1;
          end
        end
      end
      if (acc) jq.push_back('{ch: int'(ic), have: 1'b0, val: '0});
    end
    #1;
  endtask

  task automatic idle(input bit rr);
    run_cycle(1'b0, 1'b0, '0, '0, '0, rr);
  endtask

  task automatic issue(input int ch, input bit rr);
    run_cycle(1'b0, 1'b1, CW'(ch), '0, '0, rr);
  endtask

  task automatic result(input int ch, input logic [W-1:0] v, input bit rr);
    logic [N*W-1:0] d;
    logic [N-1:0]   m;
    d = '0; m = '0;
    d[ch*W +: W] = v;
    m[ch] = 1'b1;
    run_cycle(1'b0, 1'b0, '0, m, d, rr);
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_vld = 1'b0; issue_ch = '0; ch_res_vld = '0; ch_res = '0; res_rdy = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    jq.delete(); e_err_iss = 1'b0; e_err_unx = 1'b0;
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL reset_res_vld got %0b want 0", res_vld); end
    checks++; if (res !== 32'd0 || res_ch !== 2'd0) begin errors++; $display("FAIL reset_res got %0d/%0d want 0/0", res, res_ch); end
    checks++; if (ch_free !== 4'hf) begin errors++; $display("FAIL reset_ch_free got %b want 1111", ch_free); end
    checks++; if (err_issue !== 1'b0 || err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err got %0b%0b want 00", err_issue, err_unexp); end
    checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL reset_issue_rdy got %0b want 1", issue_rdy); end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] vals [4] = '{32'd10, 32'd20, 32'd30, 32'd40};
    for (int c = 0; c < 4; c++) issue(c, 1'b1);
    for (int c = 0; c < 4; c++) begin
      result(c, vals[c], 1'b1);
      checks++;
      if (res_vld !== 1'b1 || res !== vals[c] || res_ch !== CW'(c)) begin
        errors++; $display("FAIL rr_order got %0b/%0d/%0d want 1/%0d/%0d", res_vld, res, res_ch, vals[c], c);
      end
    end
    idle(1'b1);
    checks++; if (ch_free !== 4'hf) begin errors++; $display("FAIL rr_free got %b want 1111", ch_free); end
  endtask

  task automatic test_out_of_order();
    for (int c = 0; c < 3; c++) issue(c, 1'b1);
    idle(1'b1);
    result(2, 32'd300, 1'b1);
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL ooo_early got %0b want 0", res_vld); end
    idle(1'b1);
    result(0, 32'd100, 1'b1);
    checks++; if (res !== 32'd100) begin errors++; $display("FAIL ooo_first got %0d want 100", res); end
    idle(1'b1);
    checks++; if (res_vld !== 1'b0) begin errors++; $display("FAIL ooo_gap got %0b want 0", res_vld); end
    result(1, 32'd200, 1'b1);
    checks++; if (res !== 32'd200) begin errors++; $display("FAIL ooo_second got %0d want 200", res); end
    idle(1'b1);
    checks++; if (res !== 32'd300 || res_ch !== 2'd2) begin errors++; $display("FAIL ooo_third got %0d/%0d want 300/2", res, res_ch); end
    idle(1'b1);
  endtask

  task automatic test_backpressure();
    issue(1, 1'b0);
    result(1, 32'd77, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      checks++;
      if (res_vld !== 1'b1 || res !== 32'd77 || ch_free[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold got %0b/%0d/%0b want 1/77/0", res_vld, res, ch_free[1]);
      end
    end
    issue(1, 1'b0);
    checks++; if (err_issue !== 1'b1) begin errors++; $display("FAIL bp_err_issue got %0b want 1", err_issue); end
    issue(1, 1'b1);
    checks++; if (err_issue !== 1'b1 || ch_free[1] !== 1'b1) begin errors++; $display("FAIL bp_pop_issue got %0b/%0b want 1/1", err_issue, ch_free[1]); end
    idle(1'b1);
  endtask

  task automatic test_unexpected();
    result(3, 32'd123, 1'b1);
    checks++; if (err_unexp !== 1'b1 || res_vld !== 1'b0 || ch_free !== 4'hf) begin
      errors++; $display("FAIL unexp got %0b/%0b/%b want 1/0/1111", err_unexp, res_vld, ch_free);
    end
    idle(1'b1);
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL unexp_pulse got %0b want 0", err_unexp); end
  endtask

  task automatic test_multi();
    logic [N*W-1:0] d;
    issue(0, 1'b1);
    issue(1, 1'b1);
    d = '0; d[0 +: W] = 32'd5; d[W +: W] = 32'd6;
    run_cycle(1'b0, 1'b0, '0, 4'b0011, d, 1'b1);
    checks++; if (res !== 32'd5) begin errors++; $display("FAIL multi_first got %0d want 5", res); end
    idle(1'b1);
    checks++; if (res !== 32'd6 || res_ch !== 2'd1) begin errors++; $display("FAIL multi_second got %0d/%0d want 6/1", res, res_ch); end
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) issue(c, 1'b0);
    result(0, 32'd9, 1'b0);
    run_cycle(1'b1, 1'b0, '0, '0, '0, 1'b0);
    checks++; if (res_vld !== 1'b0 || ch_free !== 4'hf) begin errors++; $display("FAIL mid_reset got %0b/%b want 0/1111", res_vld, ch_free); end
    result(1, 32'd1, 1'b1);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL mid_late got %0b want 1", err_unexp); end
    issue(2, 1'b1);
    result(2, 32'd55, 1'b1);
    checks++; if (res !== 32'd55 || res_ch !== 2'd2) begin errors++; $display("FAIL mid_new got %0d/%0d want 55/2", res, res_ch); end
    idle(1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0]   m;
    logic [N*W-1:0] d;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) begin
        m[c] = ($urandom_range(0, 3) == 0);
        d[c*W +: W] = $urandom;
      end
      run_cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1,
                CW'($urandom_range(0, N - 1)), m, d, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_out_of_order();
    test_backpressure();
    test_unexpected();
    test_multi();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
